l2_mem_cut_array: RTL and testbench
===================================

# l2_mem_cut_array

Multi-port, word-addressed SRAM cut array for the L2 memory. It serves N_PORTS independent single-word request ports and builds storage from a grid of N_PAR_CUTS columns × N_SER_CUTS rows of `sram` cuts. Words are interleaved across columns. Each cut has its own round-robin arbiter, so requests to different cuts proceed in parallel. Read data is pipelined through OUT_REGS optional register stages.

## Interface
- N_PORTS, 2: number of request ports, ≥1
- N_PAR_CUTS, 8: cut columns, power of 2
- N_SER_CUTS, 4: cut rows, power of 2, ≥1
- CUT_DW, 64: cut/port data width [bit], power of 2, ≥8
- CUT_N_WORDS, 16384: words per cut, power of 2
- OUT_REGS, 0: read-data pipeline stages after the cut, 0..2
- ADDR_W (derived): $clog2(N_PAR_CUTS·N_SER_CUTS·CUT_N_WORDS)

Ports (per-port signals are arrays [N_PORTS]):
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  N_PORTS  request valid
- gnt_o  out  N_PORTS  request accepted this cycle (combinational from req_i/addr_i)
- addr_i  in  N_PORTS×ADDR_W  word address
- we_i  in  N_PORTS  1 = write, 0 = read
- wdata_i  in  N_PORTS×CUT_DW  write data
- be_i  in  N_PORTS×CUT_DW/8  byte enables (writes only)
- rvalid_o  out  N_PORTS  read data valid
- rdata_o  out  N_PORTS×CUT_DW  read data

## Operation
- **Address decode:**
  - col = addr[C-1:0], where C = $clog2(N_PAR_CUTS).
  - word = addr[C+:$clog2(CUT_N_WORDS)].
  - row = the remaining top bits. There is no row field when N_SER_CUTS = 1.
- **Arbitration:**
  - Each cut (col,row) has a round-robin arbiter over the ports whose req_i targets it.
  - The winner gets gnt_o = 1 in the same cycle. Losers get gnt_o = 0 and must hold req_i and all payload until granted.
  - Ports targeting different cuts are granted simultaneously. Two ports in the same column but different rows do not conflict.
- **RR pointer:** one per cut, reset 0. On any grant it moves to (winner+1) mod N_PORTS. It is unchanged if the cut has no grant that cycle.
  - Priority is the pointer value first, then ascending port index with wrap-around.
- **Cut access:**
  - The granted port's we/word/wdata/be drive the cut, with req = 1.
  - Writes honour be_i per byte. A write with be_i = 0 is still granted and leaves memory unchanged.
  - Writes produce no response.
- **Read return:**
  - Each port has a pipeline tracking valid, col and row, depth 1+OUT_REGS.
  - rdata_o is muxed from the tracked cut's output, registered through OUT_REGS stages.
  - rvalid_o pulses for one cycle per granted read.
- **Read-during-write:** a read and a write never target the same cut in one cycle, because there is one grant per cut.
  - A read granted the cycle after a write to the same word returns the new data.
- **Reset:**
  - All pipeline valids, RR pointers and output registers clear.
  - Memory contents are not cleared.
  - A read granted in the cycle rst_i is high, or in flight when rst_i rises, never produces rvalid_o.
  - Cut `rst_ni` is driven with !rst_i.

## Timing
- gnt_o is combinational from req_i and addr_i. There is no combinational path from gnt_o back into the block.
- Read latency: rvalid_o/rdata_o are asserted exactly 1+OUT_REGS cycles after the gnt cycle. Examples:
  - OUT_REGS = 0: valid in cycle t+1.
  - OUT_REGS = 2: valid in cycle t+3.
- Throughput: one access per cut per cycle. Each port issues back-to-back accesses every cycle when uncontended.
- Response order per port equals grant order. There is no backpressure on rvalid_o; the consumer always accepts.
- Reset values: gnt_o = 0 while rst_i = 1 (requests are ignored). rvalid_o = 0 and rdata_o = 0 during and after reset.

## Structure
- Package `l2_mem_pkg`:
  - function computing ADDR_W and field offsets
  - typedef of the per-port request struct {we, addr, wdata, be}
  - typedef of the response-tracking entry {valid, col, row}
- Sub-module `l2_cut_rr_arb` (N_PORTS-input round-robin arbiter with pointer register), instantiated once per cut.
- Cuts reuse the existing `sram` (latency 1).

## Test plan
Configuration: N_PORTS=2, N_PAR_CUTS=2, N_SER_CUTS=2, CUT_DW=32, CUT_N_WORDS=16, OUT_REGS=1, so ADDR_W=6. In each address, col = a[0], word = a[4:1], row = a[5].

- **Write/read, full strobes:** P0 writes 0xDEADBEEF to a=0x05 with be=0xF, then reads 0x05 → rvalid_o[0] = 1 exactly 2 cycles after the read gnt, rdata_o[0] = 0xDEADBEEF.
- **Partial strobes:** write 0x11223344 with be=0xF, then 0xAABBCCDD with be=0x5 to a=0x02; read → 0x11BB33DD.
- **Same-cut contention:** P0 and P1 both read a=0x04 continuously from reset → grants alternate P0, P1, P0, …. Each port gets one rvalid per grant, 2 cycles later.
- **No conflict, same column:** P0 reads a=0x00 and P1 reads a=0x20 (same col, different row) in the same cycle → both gnt_o = 1, and both rvalid_o are asserted in the same later cycle.
- **Back-to-back stream:** P0 reads a=0..31 on consecutive cycles after preloading each word with its own address → 32 consecutive rvalid cycles with rdata = 0..31 in order.
- **Reset mid-flight:** grant a read, assert rst_i on the next cycle → no rvalid_o ever appears for it. After release, the RR pointer is 0: a contended request from both ports grants P0 first, and memory data written before reset is preserved.

Source files
------------

// File: rtl/l2_mem_pkg.sv
// ============================================================================
// Package : l2_mem_pkg
// Brief   : Shared types and sizing helpers for the L2 SRAM cut array.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_mem_pkg;

    // Carrier widths for the request/tracking types; instances use the low bits.
    localparam int L2_MAX_ADDR_W = 32;
    localparam int L2_MAX_DW     = 1024;
    localparam int L2_MAX_BE_W   = L2_MAX_DW / 8;
    localparam int L2_IDX_W      = 8;

    function automatic int l2_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int l2_addr_w(input int n_par, input int n_ser, input int n_words);
        return $clog2(n_par * n_ser * n_words);
    endfunction

    function automatic int l2_word_off(input int n_par);
        return $clog2(n_par);
    endfunction

    function automatic int l2_row_off(input int n_par, input int n_words);
        return $clog2(n_par) + $clog2(n_words);
    endfunction

    typedef struct packed {
        logic                     we;
        logic [L2_MAX_ADDR_W-1:0] addr;
        logic [L2_MAX_DW-1:0]     wdata;
        logic [L2_MAX_BE_W-1:0]   be;
    } l2_req_t;

    typedef struct packed {
        logic                valid;
        logic [L2_IDX_W-1:0] col;
        logic [L2_IDX_W-1:0] row;
    } l2_trk_t;

endpackage

`default_nettype wire

// File: rtl/l2_mem_cut_array_arb.sv
// ============================================================================
// Module : l2_cut_rr_arb
// Brief  : Round-robin arbiter for one cut; pointer moves past each winner.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_cut_rr_arb #(
    parameter int N_PORTS = 2,
    localparam int IDX_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_PORTS-1:0] req_i,
    output logic [N_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] ptr_d, ptr_q;

    always_comb begin
        int j;
        j       = 0;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_PORTS; k++) begin
            j = (int'(ptr_q) + k) % N_PORTS;
            if (!valid_o && req_i[j]) begin
                valid_o  = 1'b1;
                idx_o    = IDX_W'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (valid_o) begin
            ptr_d = (int'(idx_o) == N_PORTS - 1) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sram.sv
// ============================================================================
// Module : sram
// Brief  : Single-port byte-writable SRAM cut, one-cycle read latency.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_WORDS  = 1024,
    localparam int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_d, rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (req_i && !we_i) begin
            rdata_d = mem[addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_i && we_i) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/l2_mem_cut_array.sv
// ============================================================================
// Module : l2_mem_cut_array
// Brief  : Multi-port word-interleaved SRAM cut array with per-cut RR arbiters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_mem_cut_array
    import l2_mem_pkg::*;
#(
    parameter int  N_PORTS     = 2,
    parameter int  N_PAR_CUTS  = 8,
    parameter int  N_SER_CUTS  = 4,
    parameter int  CUT_DW      = 64,
    parameter int  CUT_N_WORDS = 16384,
    parameter int  OUT_REGS    = 0,
    localparam int ADDR_W      = l2_addr_w(N_PAR_CUTS, N_SER_CUTS, CUT_N_WORDS)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [N_PORTS-1:0]                req_i,
    output logic [N_PORTS-1:0]                gnt_o,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [N_PORTS-1:0]                we_i,
    input  logic [N_PORTS-1:0][CUT_DW-1:0]    wdata_i,
    input  logic [N_PORTS-1:0][CUT_DW/8-1:0]  be_i,
    output logic [N_PORTS-1:0]                rvalid_o,
    output logic [N_PORTS-1:0][CUT_DW-1:0]    rdata_o
);

    localparam int N_CUTS   = N_PAR_CUTS * N_SER_CUTS;
    localparam int WORD_W   = (CUT_N_WORDS > 1) ? $clog2(CUT_N_WORDS) : 1;
    localparam int BE_W     = CUT_DW / 8;
    localparam int PORT_W   = l2_idx_w(N_PORTS);
    localparam int WORD_OFF = l2_word_off(N_PAR_CUTS);
    localparam int ROW_OFF  = l2_row_off(N_PAR_CUTS, CUT_N_WORDS);

    l2_req_t             w_req      [N_PORTS];
    logic [L2_IDX_W-1:0] w_col      [N_PORTS];
    logic [L2_IDX_W-1:0] w_row      [N_PORTS];
    logic [WORD_W-1:0]   w_word     [N_PORTS];
    logic [N_PORTS-1:0]  w_cut_gnt  [N_CUTS];
    logic [CUT_DW-1:0]   w_cut_rdata[N_CUTS];
    l2_trk_t             trk_d      [N_PORTS];
    l2_trk_t             trk_q      [N_PORTS];
    logic [CUT_DW-1:0]   w_rd0      [N_PORTS];
    logic [CUT_DW-1:0]   w_rd       [N_PORTS];
    logic [N_PORTS-1:0]  w_rv;
    logic                w_unused;

    always_comb begin
        w_unused = 1'b0;
        for (int p = 0; p < N_PORTS; p++) begin
            w_req[p]  = '{we:    we_i[p],
                          addr:  L2_MAX_ADDR_W'(addr_i[p]),
                          wdata: L2_MAX_DW'(wdata_i[p]),
                          be:    L2_MAX_BE_W'(be_i[p])};
            w_col[p]  = L2_IDX_W'(w_req[p].addr & L2_MAX_ADDR_W'(N_PAR_CUTS - 1));
            w_word[p] = WORD_W'(w_req[p].addr >> WORD_OFF);
            // With a single row the shifted address is always zero.
            w_row[p]  = L2_IDX_W'(w_req[p].addr >> ROW_OFF);
            w_unused  = w_unused ^ (^w_req[p]);
        end
    end

    for (genvar c = 0; c < N_CUTS; c++) begin : g_cut
        localparam int COL = c % N_PAR_CUTS;
        localparam int ROW = c / N_PAR_CUTS;

        logic [N_PORTS-1:0] w_creq;
        logic [PORT_W-1:0]  w_win;
        logic               w_any;

        always_comb begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_creq[p] = req_i[p] && !rst_i
                            && (w_col[p] == L2_IDX_W'(COL))
                            && (w_row[p] == L2_IDX_W'(ROW));
            end
        end

        l2_cut_rr_arb #(
            .N_PORTS (N_PORTS)
        ) u_arb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_i   (w_creq),
            .gnt_o   (w_cut_gnt[c]),
            .idx_o   (w_win),
            .valid_o (w_any)
        );

        sram #(
            .DATA_WIDTH (CUT_DW),
            .NUM_WORDS  (CUT_N_WORDS)
        ) u_sram (
            .clk_i   (clk_i),
            .rst_ni  (!rst_i),
            .req_i   (w_any),
            .we_i    (w_req[w_win].we),
            .addr_i  (w_word[w_win]),
            .wdata_i (w_req[w_win].wdata[CUT_DW-1:0]),
            .be_i    (w_req[w_win].be[BE_W-1:0]),
            .rdata_o (w_cut_rdata[c])
        );
    end

    always_comb begin
        gnt_o = '0;
        for (int c = 0; c < N_CUTS; c++) begin
            gnt_o = gnt_o | w_cut_gnt[c];
        end
    end

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            trk_d[p] = '{valid: gnt_o[p] && !w_req[p].we, col: w_col[p], row: w_row[p]};
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < N_PORTS; p++) begin
            if (rst_i) begin
                trk_q[p] <= '0;
            end else begin
                trk_q[p] <= trk_d[p];
            end
        end
    end

    // Idle ports carry zero so the optional output stages stay zero between reads.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            w_rd0[p] = '0;
            for (int c = 0; c < N_CUTS; c++) begin
                if (trk_q[p].valid
                    && (trk_q[p].col == L2_IDX_W'(c % N_PAR_CUTS))
                    && (trk_q[p].row == L2_IDX_W'(c / N_PAR_CUTS))) begin
                    w_rd0[p] = w_cut_rdata[c];
                end
            end
        end
    end

    if (OUT_REGS == 0) begin : g_no_oreg
        always_comb begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_rv[p] = trk_q[p].valid;
                w_rd[p] = w_rd0[p];
            end
        end
    end else begin : g_oreg
        logic [OUT_REGS-1:0] vld_d [N_PORTS];
        logic [OUT_REGS-1:0] vld_q [N_PORTS];
        logic [CUT_DW-1:0]   dat_d [N_PORTS][OUT_REGS];
        logic [CUT_DW-1:0]   dat_q [N_PORTS][OUT_REGS];

        always_comb begin
            for (int p = 0; p < N_PORTS; p++) begin
                vld_d[p]    = vld_q[p];
                dat_d[p]    = dat_q[p];
                vld_d[p][0] = trk_q[p].valid;
                dat_d[p][0] = w_rd0[p];
                for (int k = 1; k < OUT_REGS; k++) begin
                    vld_d[p][k] = vld_q[p][k-1];
                    dat_d[p][k] = dat_q[p][k-1];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            for (int p = 0; p < N_PORTS; p++) begin
                for (int k = 0; k < OUT_REGS; k++) begin
                    if (rst_i) begin
                        vld_q[p][k] <= 1'b0;
                        dat_q[p][k] <= '0;
                    end else begin
                        vld_q[p][k] <= vld_d[p][k];
                        dat_q[p][k] <= dat_d[p][k];
                    end
                end
            end
        end

        always_comb begin
            for (int p = 0; p < N_PORTS; p++) begin
                w_rv[p] = vld_q[p][OUT_REGS-1];
                w_rd[p] = dat_q[p][OUT_REGS-1];
            end
        end
    end

    // Masking with rst_i keeps responses quiet during reset for any OUT_REGS depth.
    always_comb begin
        for (int p = 0; p < N_PORTS; p++) begin
            rvalid_o[p] = w_rv[p] && !rst_i;
            rdata_o[p]  = rst_i ? '0 : w_rd[p];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_l2_mem_cut_array.sv
// ============================================================================
// Module : tb_l2_mem_cut_array
// Brief  : Scoreboard bench for l2_mem_cut_array (2 ports, 2x2 cuts, OUT_REGS=1).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_mem_cut_array;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req = '0;
    logic [1:0]       we  = '0;
    logic [1:0][5:0]  addr  = '0;
    logic [1:0][31:0] wdata = '0;
    logic [1:0][3:0]  be    = '0;
    logic [1:0]       gnt;
    logic [1:0]       rvalid;
    logic [1:0][31:0] rdata;

    always #5 clk = ~clk;

    l2_mem_cut_array #(
        .N_PORTS     (2),
        .N_PAR_CUTS  (2),
        .N_SER_CUTS  (2),
        .CUT_DW      (32),
        .CUT_N_WORDS (16),
        .OUT_REGS    (1)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .gnt_o    (gnt),
        .addr_i   (addr),
        .we_i     (we),
        .wdata_i  (wdata),
        .be_i     (be),
        .rvalid_o (rvalid),
        .rdata_o  (rdata)
    );

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        known;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    exp_t        sbq [2][$];
    logic [31:0] model [64];
    logic        known [64];
    int          rv_cnt [2];
    logic [31:0] last_rd [2];

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: model memory on write grants, predict reads, check responses.
    initial begin
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        rv_cnt[0] = 0;  rv_cnt[1] = 0;
        last_rd[0] = '0; last_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_eq("rst_gnt", 64'(gnt), 64'd0);
                chk_eq("rst_rvalid", 64'(rvalid), 64'd0);
                chk_eq("rst_rdata", 64'(rdata), 64'd0);
                sbq[0].delete();
                sbq[1].delete();
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (sbq[p].size() > 0 && sbq[p][0].cyc < cyc) begin
                        chk_eq("rvalid_missing", 64'(rvalid[p]), 64'd1);
                        void'(sbq[p].pop_front());
                    end
                    if (rvalid[p]) begin
                        rv_cnt[p]++;
                        last_rd[p] = rdata[p];
                        if (sbq[p].size() == 0) begin
                            chk_eq("rvalid_unexp", 64'(rvalid[p]), 64'd0);
                        end else begin
                            e = sbq[p].pop_front();
                            chk_eq("rlat", 64'(cyc), 64'(e.cyc));
                            if (e.known) chk_eq("rdata", 64'(rdata[p]), 64'(e.d));
                        end
                    end
                    if (gnt[p]) begin
                        if (!req[p]) chk_eq("gnt_noreq", 64'(gnt[p]), 64'd0);
                        if (we[p]) begin
                            for (int b = 0; b < 4; b++) begin
                                if (be[p][b]) model[addr[p]][b*8 +: 8] = wdata[p][b*8 +: 8];
                            end
                            if (be[p] == 4'hF) known[addr[p]] = 1'b1;
                        end else begin
                            sbq[p].push_back('{cyc: cyc + 2, d: model[addr[p]], known: known[addr[p]]});
                        end
                    end
                end
            end
        end
    end

    task automatic acc(input int p, input logic w, input logic [5:0] a,
                       input logic [31:0] d, input logic [3:0] b, output int waited);
        req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = b;
        waited = 0;
        @(negedge clk);
        while (!gnt[p] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!gnt[p]) chk_eq("acc_timeout", 64'(gnt[p]), 64'd1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int base;
        // Both ports contend on one cut while reset is still asserted.
        req = 2'b11; we = 2'b00; addr[0] = 6'h04; addr[1] = 6'h04;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_eq("contend_gnt", 64'(gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
            @(posedge clk); #1;
        end
        req = 2'b00;
        idle(3);

        acc(0, 1'b1, 6'h05, 32'hDEADBEEF, 4'hF, n);
        acc(0, 1'b0, 6'h05, 32'h0, 4'h0, n);
        idle(3);
        chk_eq("wr_rd", 64'(last_rd[0]), 64'hDEADBEEF);

        acc(0, 1'b1, 6'h02, 32'h11223344, 4'hF, n);
        acc(0, 1'b1, 6'h02, 32'hAABBCCDD, 4'h5, n);
        acc(0, 1'b0, 6'h02, 32'h0, 4'h0, n);
        idle(3);
        chk_eq("pstrb", 64'(last_rd[0]), 64'h11BB33DD);

        acc(0, 1'b1, 6'h00, 32'h0000A000, 4'hF, n);
        acc(1, 1'b1, 6'h20, 32'h0000B020, 4'hF, n);
        req = 2'b11; we = 2'b00; addr[0] = 6'h00; addr[1] = 6'h20;
        @(negedge clk);
        chk_eq("nocfl_gnt", 64'(gnt), 64'd3);
        @(posedge clk); #1;
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk_eq("nocfl_rv", 64'(rvalid), 64'd3);
        idle(3);

        for (int a = 0; a < 32; a++) acc(0, 1'b1, 6'(a), 32'(a), 4'hF, n);
        base = rv_cnt[0];
        for (int a = 0; a < 32; a++) begin
            acc(0, 1'b0, 6'(a), 32'h0, 4'h0, n);
            if (a % 8 == 0) chk_eq("stream_gnt_wait", 64'(n), 64'd0);
        end
        idle(4);
        chk_eq("stream_cnt", 64'(rv_cnt[0] - base), 64'd32);

        // Reset while a read is in flight; cut 0 pointer is left at P1 beforehand.
        acc(0, 1'b1, 6'h0A, 32'hCAFEF00D, 4'hF, n);
        acc(0, 1'b0, 6'h04, 32'h0, 4'h0, n);
        idle(4);
        base = rv_cnt[0];
        acc(0, 1'b0, 6'h0A, 32'h0, 4'h0, n);
        rst = 1'b1;
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 6'h06;
        idle(2);
        rst = 1'b0;
        req = 2'b11; we = 2'b00; addr[0] = 6'h04; addr[1] = 6'h04;
        @(negedge clk);
        chk_eq("rst_ptr_p0", 64'(gnt), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_eq("rst_ptr_p1", 64'(gnt), 64'd2);
        @(posedge clk); #1;
        req = 2'b00;
        idle(4);
        chk_eq("rst_drop", 64'(rv_cnt[0] - base), 64'd1);

        acc(1, 1'b0, 6'h0A, 32'h0, 4'h0, n);
        idle(3);
        chk_eq("rst_mem", 64'(last_rd[1]), 64'hCAFEF00D);

        idle(4);
        chk_eq("sb_empty", 64'(sbq[0].size() + sbq[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
